alu_uart_sequencer: RTL and testbench

Frame sequencer that sits between the UART byte receiver/transmitter and the `ALU` datapath. It collects a three-byte frame (operand A, operand B, opcode) from the RX side, drives the ALU operands and opcode, and waits out the ALU's one-cycle registered latency. It then returns the result byte to the TX side through a start/done handshake. It replaces the board switches/buttons as the ALU's input source.

---
 rtl/alu_uart_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer.sv
// Frame sequencer between a UART byte link and a registered ALU: collects A, B, opcode,
// waits out the ALU latency and hands the result byte to the transmitter.
// Optional opcode screening is enabled by defining ALU_SEQ_OPCHECK_EN.
module alu_uart_sequencer #(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_OPS  = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_done,
  input  logic [N_BITS-1:0] alu_result,
  output logic [N_BITS-1:0] alu_a,
  output logic [N_BITS-1:0] alu_b,
  output logic [N_OPS-1:0]  alu_op,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              op_err
);

  typedef enum logic [2:0] {
    StWaitA, StWaitB, StWaitOp, StExec, StSend, StWaitTx
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
  logic [N_OPS-1:0]  op_q, op_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              op_err_q, op_err_d;
  logic              op_ok;

`ifdef ALU_SEQ_OPCHECK_EN
  logic [7:0] op_byte;

  always_comb begin
    op_byte = '0;
    op_byte[N_OPS-1:0] = rx_data[N_OPS-1:0];
    case (op_byte)
      8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end
`else
  assign op_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    op_err_d   = 1'b0;
    case (state_q)
      StWaitA: begin
        if (rx_valid) begin
          a_d     = rx_data[N_BITS-1:0];
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (rx_valid) begin
          b_d     = rx_data[N_BITS-1:0];
          state_d = StWaitOp;
        end
      end
      StWaitOp: begin
        if (rx_valid) begin
          if (op_ok) begin
            op_d    = rx_data[N_OPS-1:0];
            cnt_d   = '0;
            state_d = StExec;
          end else begin
            op_err_d = 1'b1;
            state_d  = StWaitA;
          end
        end
      end
      // First cycle lets the ALU register, second lets its output settle.
      StExec: begin
        if (cnt_q == 2'd1) begin
          state_d = StSend;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StSend: begin
        tx_data_d              = '0;
        tx_data_d[N_BITS-1:0]  = alu_result;
        tx_start_d             = 1'b1;
        state_d                = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          state_d = StWaitA;
        end
      end
      default: state_d = StWaitA;
    endcase
    busy_d = (state_d != StWaitA);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StWaitA;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      op_err_q   <= op_err_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign op_err   = op_err_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: a registered ALU stand-in plus a frame-level model that
// predicts the transmitted byte, error pulse and held operands for directed and random frames.
`timescale 1ns/1ps
module tb_alu_uart_sequencer;
  localparam int unsigned NB = 8;
  localparam int unsigned NO = 6;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_done = 1'b0;
  logic [NB-1:0] alu_result;
  logic [NB-1:0] alu_a, alu_b;
  logic [NO-1:0] alu_op;
  logic [7:0]    tx_data;
  logic          tx_start, busy, op_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Frame-level model state: last forwarded opcode, ALU register, last sent byte.
  logic [NO-1:0] m_op  = '0;
  logic [7:0]    m_res = 8'h00;
  logic [7:0]    m_tx  = 8'h00;
  logic [7:0]    m_a   = 8'h00;
  logic [7:0]    valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

  logic [NB-1:0] alu_reg = '0;
  assign alu_result = alu_reg;

  alu_uart_sequencer #(.N_BITS(NB), .N_OPS(NO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_done    (tx_done),
    .alu_result (alu_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .op_err     (op_err)
  );

  always #5 clock = ~clock;

  function automatic bit op_valid(input logic [7:0] op);
    return (op == 8'h20) || (op == 8'h22) || (op == 8'h24) || (op == 8'h25) ||
           (op == 8'h26) || (op == 8'h03) || (op == 8'h02) || (op == 8'h27);
  endfunction

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] op);
    case (op)
      8'h20:   return a + b;
      8'h22:   return a - b;
      8'h24:   return a & b;
      8'h25:   return a | b;
      8'h26:   return a ^ b;
      8'h27:   return ~(a | b);
      8'h02:   return a >> b;
      8'h03:   return 8'($signed(a) >>> b);
      default: return 8'h00;
    endcase
  endfunction

  // ALU stand-in: registers every cycle, holds on undefined opcodes.
  always @(posedge clock) begin
    if (op_valid(8'(alu_op))) alu_reg <= alu_f(alu_a, alu_b, 8'(alu_op));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic gap_cycles(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      tx_done = noise;
      tick();
      tx_done = 1'b0;
    end
  endtask

  // end_mode: 0 plain tx_done, 1 stray RX byte before tx_done, 2 RX byte together with tx_done
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int gap, input bit noise, input int end_mode);
    logic [7:0] op;
    bit         exp_err;
    op = {2'b00, opb[NO-1:0]};
    // Operands land before the opcode, so the old opcode is applied to them first.
    if (op_valid(8'(m_op))) m_res = alu_f(a, b, 8'(m_op));
    exp_err = 1'b0;
`ifdef ALU_SEQ_OPCHECK_EN
    exp_err = !op_valid(op);
`endif
    if (!exp_err) begin
      m_op = op[NO-1:0];
      if (op_valid(op)) m_res = alu_f(a, b, op);
    end
    m_a = a;

    send_byte(a);
    gap_cycles(gap, noise);
    send_byte(b);
    gap_cycles(gap, noise);
    send_byte(opb);
    chk("alu_a", 32'(alu_a), 32'(a));
    chk("alu_b", 32'(alu_b), 32'(b));
    chk("alu_op", 32'(alu_op), 32'(m_op));
    chk("op_err", 32'(op_err), 32'(exp_err));
    chk("busy_after_op", 32'(busy), 32'(!exp_err));
    if (exp_err) begin
      tick();
      chk("op_err_one_cycle", 32'(op_err), 32'd0);
      chk("busy_after_err", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("no_tx_on_err", 32'(tx_start), 32'd0);
      end
      chk("tx_data_held", 32'(tx_data), 32'(m_tx));
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (noise) begin
        rx_data  = 8'($urandom);
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      chk("tx_start_early", 32'(tx_start), 32'd0);
    end
    tick();
    m_tx = m_res;
    chk("tx_start", 32'(tx_start), 32'd1);
    chk("tx_data", 32'(tx_data), 32'(m_tx));
    chk("op_err_quiet", 32'(op_err), 32'd0);
    tick();
    chk("tx_start_pulse", 32'(tx_start), 32'd0);
    chk("busy_wait_tx", 32'(busy), 32'd1);
    chk("alu_a_exec_drop", 32'(alu_a), 32'(m_a));
    if (end_mode == 1) begin
      send_byte(8'h11);
      chk("stray_rx_a", 32'(alu_a), 32'(m_a));
      chk("stray_rx_busy", 32'(busy), 32'd1);
    end
    rx_data  = 8'h55;
    rx_valid = (end_mode == 2);
    tx_done  = 1'b1;
    tick();
    tx_done  = 1'b0;
    rx_valid = 1'b0;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("tx_start_after_done", 32'(tx_start), 32'd0);
    chk("alu_a_after_done", 32'(alu_a), 32'(m_a));
    chk("tx_data_hold", 32'(tx_data), 32'(m_tx));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_err"}, 32'(op_err), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb, ro;
    #12;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    run_frame(8'h05, 8'h03, 8'h20, 0, 1'b0, 0);   // ADD
    run_frame(8'h03, 8'h05, 8'h22, 0, 1'b0, 0);   // SUB wraps
    run_frame(8'hF0, 8'h02, 8'h02, 1, 1'b0, 1);   // SRL, stray 0x11 in WAIT_TX
    run_frame(8'h0F, 8'h01, 8'h24, 0, 1'b0, 0);   // AND

    // Abort a frame half way with reset.
    send_byte(8'h07);
    send_byte(8'h09);
    reset_n = 1'b0;
    #1;
    m_op = '0;
    m_tx = 8'h00;
    check_reset_outputs("mid_reset");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_reset_outputs("post_reset");
    run_frame(8'h01, 8'h01, 8'h25, 0, 1'b0, 2);   // OR, then RX+tx_done together
    run_frame(8'h3A, 8'hC5, 8'h26, 0, 1'b0, 0);   // 0x55 must not have become A

    for (int k = 0; k < 12; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = {2'($urandom_range(0, 3)), valid_ops[$urandom_range(0, 7)][5:0]};
      run_frame(ra, rb, ro, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2));
    end

    run_frame(8'h01, 8'h02, 8'h3F, 0, 1'b0, 0);   // undefined opcode
    run_frame(8'h21, 8'h12, 8'h20, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end
endmodule
